// File: rtl/datapath_test_sequencer.sv
// Programmable microcode sequencer for the register-file/ALU datapath.
// It has single-run, loop and single-step modes and an optional per-word result check.
module datapath_test_sequencer #(
    parameter int          DATA_W   = 16,
    parameter int          NUM_REGS = 16,
    parameter int          RA_W     = 4,
    parameter int          DEPTH    = 32,
    parameter int          PC_W     = 5,
    parameter int          ERR_W    = 8,
    parameter logic [3:0]  NOP_OP   = 4'h0,
    localparam int         PW       = 1 + 3*RA_W + DATA_W + 2 + 4 + 1 + 1 + DATA_W + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                step_mode,
    input  logic                step,
    input  logic                loop_mode,
    input  logic                prog_we,
    input  logic [PC_W-1:0]     prog_addr,
    input  logic [PW-1:0]       prog_data,
    input  logic [DATA_W-1:0]   alu_result,
    output logic [NUM_REGS-1:0] reg_en,
    output logic [RA_W-1:0]     reg_a,
    output logic [RA_W-1:0]     reg_b,
    output logic [DATA_W-1:0]   imm,
    output logic [1:0]          b_sel,
    output logic [3:0]          opcode,
    output logic                flag_en,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERR_W-1:0]    err_count,
    output logic [PC_W-1:0]     fail_pc,
    output logic [15:0]         loop_count
);

    localparam int L_EXP  = 1;
    localparam int L_CHK  = L_EXP + DATA_W;
    localparam int L_FEN  = L_CHK + 1;
    localparam int L_OP   = L_FEN + 1;
    localparam int L_BSEL = L_OP + 4;
    localparam int L_IMM  = L_BSEL + 2;
    localparam int L_RB   = L_IMM + DATA_W;
    localparam int L_RA   = L_RB + RA_W;
    localparam int L_WR   = L_RA + RA_W;
    localparam int L_WEN  = L_WR + RA_W;

    typedef enum logic [1:0] {IDLE, RUN, STEP_WAIT, DONE} state_e;

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [PC_W-1:0]     fail_q, fail_d;
    logic [15:0]         loop_q, loop_d;
    logic [PW-1:0]       mem_q [DEPTH];
    logic [PW-1:0]       word_s;
    logic [RA_W-1:0]     wr_reg_s;
    logic                mismatch_s;
    logic                is_last_s;

    assign word_s     = mem_q[pc_q];
    assign wr_reg_s   = word_s[L_WR +: RA_W];
    assign mismatch_s = word_s[L_CHK] && (alu_result != word_s[L_EXP +: DATA_W]);
    assign is_last_s  = word_s[0] || (pc_q == PC_W'(DEPTH-1));

    assign busy       = (state_q == RUN) || (state_q == STEP_WAIT);
    assign done       = (state_q == DONE);
    assign pass       = done && (err_q == {ERR_W{1'b0}});
    assign err_count  = err_q;
    assign fail_pc    = fail_q;
    assign loop_count = loop_q;

    // Program memory: no reset, writable only while not running.
    always_ff @(posedge clk) begin
        if (prog_we && ((state_q == IDLE) || (state_q == DONE))) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= {PC_W{1'b0}};
            err_q   <= {ERR_W{1'b0}};
            fail_q  <= {PC_W{1'b0}};
            loop_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            loop_q  <= loop_d;
        end
    end

    // Datapath controls come from the current word only while in RUN.
    always_comb begin
        reg_en  = {NUM_REGS{1'b0}};
        reg_a   = {RA_W{1'b0}};
        reg_b   = {RA_W{1'b0}};
        imm     = {DATA_W{1'b0}};
        b_sel   = 2'b00;
        opcode  = NOP_OP;
        flag_en = 1'b0;
        if (state_q == RUN) begin
            reg_a   = word_s[L_RA +: RA_W];
            reg_b   = word_s[L_RB +: RA_W];
            imm     = word_s[L_IMM +: DATA_W];
            b_sel   = word_s[L_BSEL +: 2];
            opcode  = word_s[L_OP +: 4];
            flag_en = word_s[L_FEN];
            if (word_s[L_WEN] && ({1'b0, wr_reg_s} < (RA_W+1)'(NUM_REGS))) begin
                reg_en = {{(NUM_REGS-1){1'b0}}, 1'b1} << wr_reg_s;
            end else begin
                reg_en = {NUM_REGS{1'b0}};
            end
        end else begin
            opcode = NOP_OP;
        end
    end

    // Next-state, pc and result counters.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;
        fail_d  = fail_q;
        loop_d  = loop_q;
        case (state_q)
            IDLE, DONE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d = RUN;
                    pc_d    = {PC_W{1'b0}};
                    err_d   = {ERR_W{1'b0}};
                    fail_d  = {PC_W{1'b0}};
                    loop_d  = 16'h0000;
                end else begin
                    state_d = state_q;
                end
            end
            RUN: begin
                if (mismatch_s) begin
                    if (err_q != {ERR_W{1'b1}}) begin
                        err_d = err_q + ERR_W'(1);
                    end else begin
                        err_d = err_q;
                    end
                    if (err_q == {ERR_W{1'b0}}) begin
                        fail_d = pc_q;
                    end else begin
                        fail_d = fail_q;
                    end
                end else begin
                    err_d = err_q;
                end
                if (abort) begin
                    state_d = IDLE;
                end else if (is_last_s) begin
                    if (loop_mode) begin
                        pc_d    = {PC_W{1'b0}};
                        loop_d  = loop_q + 16'h0001;
                        state_d = step_mode ? STEP_WAIT : RUN;
                    end else begin
                        state_d = DONE;
                    end
                end else if (step_mode) begin
                    pc_d    = pc_q + PC_W'(1);
                    state_d = STEP_WAIT;
                end else begin
                    pc_d    = pc_q + PC_W'(1);
                end
            end
            STEP_WAIT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (step) begin
                    state_d = RUN;
                end else begin
                    state_d = STEP_WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_datapath_test_sequencer.sv
// Directed testbench for datapath_test_sequencer; a small register-file/ALU model
// drives alu_result from the sequencer's controls.
module tb_datapath_test_sequencer;

    localparam int PW = 54;
    localparam logic [3:0] OP_NOP = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3,
                           OP_OR = 4'd4, OP_XOR = 4'd5, OP_NOT = 4'd6, OP_LSH = 4'd7,
                           OP_RSHL = 4'd8, OP_RSHA = 4'd9, OP_PASSB = 4'd10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0, abort = 1'b0, step_mode = 1'b0, step = 1'b0, loop_mode = 1'b0;
    logic          prog_we = 1'b0;
    logic [4:0]    prog_addr = 5'd0;
    logic [PW-1:0] prog_data = '0;
    logic [15:0]   alu_result;
    logic [15:0]   reg_en;
    logic [3:0]    reg_a, reg_b, opcode;
    logic [15:0]   imm;
    logic [1:0]    b_sel;
    logic          flag_en, busy, done, pass;
    logic [7:0]    err_count;
    logic [4:0]    fail_pc;
    logic [15:0]   loop_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] regs [16];
    logic [15:0] op_a, op_b;
    logic [3:0]  legacy_ops [9];
    logic [15:0] legacy_exp [9];
    int cyc;

    datapath_test_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .step_mode(step_mode),
        .step(step), .loop_mode(loop_mode), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .alu_result(alu_result), .reg_en(reg_en), .reg_a(reg_a),
        .reg_b(reg_b), .imm(imm), .b_sel(b_sel), .opcode(opcode), .flag_en(flag_en),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fail_pc(fail_pc),
        .loop_count(loop_count)
    );

    always #5 clk = ~clk;

    // Reference register file and ALU.
    always_comb begin
        op_a = regs[reg_a];
        op_b = (b_sel == 2'd1) ? imm : regs[reg_b];
        case (opcode)
            OP_ADD:   alu_result = op_a + op_b;
            OP_SUB:   alu_result = op_a - op_b;
            OP_AND:   alu_result = op_a & op_b;
            OP_OR:    alu_result = op_a | op_b;
            OP_XOR:   alu_result = op_a ^ op_b;
            OP_NOT:   alu_result = ~op_a;
            OP_LSH:   alu_result = op_a << 1;
            OP_RSHL:  alu_result = op_a >> 1;
            OP_RSHA:  alu_result = {op_a[15], op_a[15:1]};
            OP_PASSB: alu_result = op_b;
            default:  alu_result = 16'h0000;
        endcase
    end

    always @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            if (reg_en[i]) regs[i] <= alu_result;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] mkw(input logic wen, input logic [3:0] wr, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [15:0] im, input logic [1:0] bs,
                                          input logic [3:0] op, input logic fen, input logic chk,
                                          input logic [15:0] ex, input logic last);
        return {wen, wr, ra, rb, im, bs, op, fen, chk, ex, last};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int addr, input logic [PW-1:0] data);
        prog_we = 1'b1;
        prog_addr = addr[4:0];
        prog_data = data;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 1000) begin
            tick();
            cycles++;
        end
    endtask

    task automatic load_legacy(input logic [15:0] exp3);
        load(0, mkw(1'b1, 4'd1, 4'd0, 4'd0, 16'd10, 2'd1, OP_PASSB, 1'b0, 1'b0, 16'd0, 1'b0));
        load(1, mkw(1'b1, 4'd2, 4'd0, 4'd0, 16'd5, 2'd1, OP_PASSB, 1'b0, 1'b0, 16'd0, 1'b0));
        for (int i = 0; i < 9; i++) begin
            load(i + 2, mkw(1'b0, 4'd0, 4'd1, 4'd2, 16'd0, 2'd0, legacy_ops[i], 1'b1, 1'b1,
                            (i == 1) ? exp3 : legacy_exp[i], i == 8));
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 16'h0000;
        legacy_ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_LSH, OP_RSHL, OP_RSHA};
        legacy_exp = '{16'd15, 16'd5, 16'd0, 16'd15, 16'd15, 16'hFFF5, 16'd20, 16'd5, 16'd5};

        // Reset state
        #23;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_pass", pass, 1'b0);
        check_eq("rst_reg_en", reg_en, 16'h0000);
        check_eq("rst_opcode", opcode, OP_NOP);
        check_eq("rst_err", err_count, 8'd0);
        check_eq("rst_loop", loop_count, 16'd0);
        rst = 1'b1;
        tick();

        // Legacy sequence
        load_legacy(16'd5);
        pulse_start();
        check_eq("leg_reg_en0", reg_en, 16'h0002);
        check_eq("leg_imm0", imm, 16'd10);
        check_eq("leg_busy", busy, 1'b1);
        wait_done(cyc);
        check_eq("leg_cycles", cyc, 11);
        check_eq("leg_pass", pass, 1'b1);
        check_eq("leg_err", err_count, 8'd0);
        check_eq("leg_idle_opcode", opcode, OP_NOP);

        // Wrong expect on word 3
        load(3, mkw(1'b0, 4'd0, 4'd1, 4'd2, 16'd0, 2'd0, OP_SUB, 1'b1, 1'b1, 16'd6, 1'b0));
        pulse_start();
        wait_done(cyc);
        check_eq("bad_cycles", cyc, 11);
        check_eq("bad_pass", pass, 1'b0);
        check_eq("bad_err", err_count, 8'd1);
        check_eq("bad_fail_pc", fail_pc, 5'd3);

        // Loop mode on a 3-word program
        for (int i = 0; i < 3; i++) begin
            load(i, mkw(1'b0, 4'd0, 4'd0, 4'd0, 16'(i), 2'd1, OP_PASSB, 1'b0, 1'b0, 16'd0, i == 2));
        end
        loop_mode = 1'b1;
        pulse_start();
        for (int i = 0; i < 10; i++) tick();
        check_eq("loop_count", loop_count, 16'd3);
        check_eq("loop_pc", imm, 16'd1);
        check_eq("loop_busy", busy, 1'b1);
        loop_mode = 1'b0;
        wait_done(cyc);
        check_eq("loop_exit_cycles", cyc, 2);
        check_eq("loop_count_held", loop_count, 16'd3);

        // Step mode on an 8-word program
        for (int i = 0; i < 8; i++) begin
            load(i, mkw(1'b1, 4'(i + 1), 4'd0, 4'd0, 16'(i), 2'd1, OP_PASSB, 1'b0, 1'b0, 16'd0, i == 7));
        end
        step_mode = 1'b1;
        pulse_start();
        check_eq("step_w0_imm", imm, 16'd0);
        tick();
        check_eq("stepw_reg_en", reg_en, 16'h0000);
        check_eq("stepw_opcode", opcode, OP_NOP);
        check_eq("stepw_busy", busy, 1'b1);
        tick();
        check_eq("stepw_hold", reg_en, 16'h0000);
        for (int s = 1; s <= 4; s++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            check_eq($sformatf("step%0d_imm", s), imm, 16'(s));
            check_eq($sformatf("step%0d_reg_en", s), reg_en, 16'h0001 << (s + 1));
            tick();
            check_eq($sformatf("step%0d_wait", s), reg_en, 16'h0000);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        check_eq("step5_imm", imm, 16'd5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_reg_en", reg_en, 16'h0000);
        check_eq("abort_imm", imm, 16'h0000);
        check_eq("abort_done", done, 1'b0);
        step_mode = 1'b0;

        // Programming while busy is ignored; while done it takes effect
        pulse_start();
        load(2, mkw(1'b1, 4'd3, 4'd0, 4'd0, 16'h0077, 2'd1, OP_PASSB, 1'b0, 1'b0, 16'd0, 1'b0));
        tick();
        check_eq("busy_write_ignored", imm, 16'd2);
        wait_done(cyc);
        check_eq("run8_cycles", cyc, 6);
        load(2, mkw(1'b1, 4'd3, 4'd0, 4'd0, 16'h0055, 2'd1, OP_PASSB, 1'b0, 1'b0, 16'd0, 1'b0));
        pulse_start();
        tick();
        tick();
        check_eq("done_write_applied", imm, 16'h0055);
        wait_done(cyc);

        // Asynchronous reset mid-run at pc 7
        pulse_start();
        for (int i = 0; i < 7; i++) tick();
        check_eq("pre_rst_imm", imm, 16'd7);
        rst = 1'b0;
        #1;
        check_eq("arst_busy", busy, 1'b0);
        check_eq("arst_reg_en", reg_en, 16'h0000);
        check_eq("arst_imm", imm, 16'h0000);
        #1;
        rst = 1'b1;
        tick();
        pulse_start();
        check_eq("post_rst_imm", imm, 16'd0);
        check_eq("post_rst_reg_en", reg_en, 16'h0002);
        wait_done(cyc);

        // Full-depth program without a last bit, every word mismatching
        for (int i = 0; i < 32; i++) begin
            load(i, mkw(1'b0, 4'd0, 4'd0, 4'd0, 16'(i), 2'd0, OP_NOP, 1'b0, 1'b1, 16'hFFFF, 1'b0));
        end
        pulse_start();
        wait_done(cyc);
        check_eq("depth_cycles", cyc, 32);
        check_eq("depth_err", err_count, 8'd32);
        check_eq("depth_fail_pc", fail_pc, 5'd0);
        loop_mode = 1'b1;
        pulse_start();
        for (int i = 0; i < 300; i++) tick();
        loop_mode = 1'b0;
        wait_done(cyc);
        check_eq("sat_exit_cycles", cyc, 20);
        check_eq("sat_err", err_count, 8'd255);
        check_eq("sat_loops", loop_count, 16'd9);
        check_eq("sat_pass", pass, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
